// File: rtl/bp_vc_ctrl.sv
// bp_vc_ctrl: sequencing controller for a shift-chain victim cache.
//
// The cache storage is an external chain of entries_p shift cells. Valid
// entries sit in cells 0..count-1 with cell 0 the newest. This block accepts
// lookup/insert requests, compares the captured tag against every cell, and
// drives one-hot start pulses into the chain:
//   shift_l_o[k] : cells k..entries_p-1 take their right neighbour (removal);
//                  the last cell's right input is tied to zero externally.
//   shift_r_o[0] : every cell takes its left neighbour; cell 0 takes ins_*.
// Inserting into a full cache first hands cell entries_p-1 out on evict_*.
//
// Ports
//   clk_i, reset             clock, synchronous active-high reset
//   req_v_i/req_ready_o      request handshake (op 0 = lookup-and-remove,
//   req_op_i/tag/data/stat   op 1 = insert)
//   resp_v_o/resp_ready_i    lookup response handshake
//   resp_hit_o/data/stat     lookup result
//   evict_v_o/evict_ready_i  evicted entry handshake
//   evict_tag/data/stat_o    evicted entry contents
//   cell_tag/data/stat_i     flattened cell contents, cell 0 in the LSBs
//   shift_r_o, shift_l_o     one-hot chain start pulses
//   ins_tag/data/stat_o      left-neighbour input of cell 0
//   count_o                  number of valid entries
module bp_vc_ctrl #(
    parameter int entries_p   = 8,
    parameter int block_width = 512,
    parameter int tag_width   = 20,
    parameter int stat_width  = 4
) (
    input  logic                              clk_i,
    input  logic                              reset,
    input  logic                              req_v_i,
    output logic                              req_ready_o,
    input  logic                              req_op_i,
    input  logic [tag_width-1:0]              req_tag_i,
    input  logic [block_width-1:0]            req_data_i,
    input  logic [stat_width-1:0]             req_stat_i,
    output logic                              resp_v_o,
    input  logic                              resp_ready_i,
    output logic                              resp_hit_o,
    output logic [block_width-1:0]            resp_data_o,
    output logic [stat_width-1:0]             resp_stat_o,
    output logic                              evict_v_o,
    input  logic                              evict_ready_i,
    output logic [tag_width-1:0]              evict_tag_o,
    output logic [block_width-1:0]            evict_data_o,
    output logic [stat_width-1:0]             evict_stat_o,
    input  logic [entries_p*tag_width-1:0]    cell_tag_i,
    input  logic [entries_p*block_width-1:0]  cell_data_i,
    input  logic [entries_p*stat_width-1:0]   cell_stat_i,
    output logic [entries_p-1:0]              shift_r_o,
    output logic [entries_p-1:0]              shift_l_o,
    output logic [tag_width-1:0]              ins_tag_o,
    output logic [block_width-1:0]            ins_data_o,
    output logic [stat_width-1:0]             ins_stat_o,
    output logic [$clog2(entries_p+1)-1:0]    count_o
);

    localparam int cnt_w = $clog2(entries_p + 1);
    localparam int idx_w = (entries_p > 1) ? $clog2(entries_p) : 1;
    localparam logic [cnt_w-1:0] full_count = cnt_w'(entries_p);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_RESP,
        S_EVICT,
        S_SHIFT_OUT,
        S_INSERT
    } state_t;

    state_t state_reg, state_next;

    logic [cnt_w-1:0]       count_reg;
    logic                   op_reg;
    logic [tag_width-1:0]   tag_reg;
    logic [block_width-1:0] data_reg;
    logic [stat_width-1:0]  stat_reg;

    logic                   resp_hit_reg;
    logic [block_width-1:0] resp_data_reg;
    logic [stat_width-1:0]  resp_stat_reg;

    logic [tag_width-1:0]   evict_tag_reg;
    logic [block_width-1:0] evict_data_reg;
    logic [stat_width-1:0]  evict_stat_reg;

    // Unflattened view of the chain and the per-cell tag match.
    logic [tag_width-1:0]   cell_tag  [entries_p];
    logic [block_width-1:0] cell_data [entries_p];
    logic [stat_width-1:0]  cell_stat [entries_p];
    logic [entries_p-1:0]   hit;

    generate
        for (genvar gi = 0; gi < entries_p; gi++) begin : g_cell
            assign cell_tag[gi]  = cell_tag_i[gi*tag_width +: tag_width];
            assign cell_data[gi] = cell_data_i[gi*block_width +: block_width];
            assign cell_stat[gi] = cell_stat_i[gi*stat_width +: stat_width];
            assign hit[gi]       = cell_stat[gi][0] & (cell_tag[gi] == tag_reg);
        end
    endgenerate

    logic                 hit_any;
    logic [idx_w-1:0]     hit_idx;
    logic [entries_p-1:0] hit_onehot;

    assign hit_any = |hit;
    // Isolate the lowest set bit: this is directly the shift-left start pulse.
    assign hit_onehot = hit & (~hit + entries_p'(1));

    always_comb begin
        hit_idx = '0;
        for (int k = entries_p - 1; k >= 0; k--) begin
            if (hit[k]) begin
                hit_idx = idx_w'(k);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_v_i) begin
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!op_reg) begin
                    state_next = S_RESP;
                end else if (hit_any) begin
                    // Duplicate is removed in place, so no eviction is needed.
                    state_next = S_INSERT;
                end else if (count_reg == full_count) begin
                    state_next = S_EVICT;
                end else begin
                    state_next = S_INSERT;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_next = S_IDLE;
                end
            end
            S_EVICT: begin
                if (evict_ready_i) begin
                    state_next = S_SHIFT_OUT;
                end
            end
            S_SHIFT_OUT: state_next = S_INSERT;
            S_INSERT:    state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Outputs. Strobes are masked during reset so nothing reaches the chain
    // or the handshakes while the controller is being cleared.
    always_comb begin
        req_ready_o = 1'b0;
        resp_v_o    = 1'b0;
        evict_v_o   = 1'b0;
        shift_r_o   = '0;
        shift_l_o   = '0;
        ins_tag_o   = '0;
        ins_data_o  = '0;
        ins_stat_o  = '0;
        if (!reset) begin
            case (state_reg)
                S_IDLE:   req_ready_o = 1'b1;
                S_LOOKUP: shift_l_o   = hit_onehot;
                S_RESP:   resp_v_o    = 1'b1;
                S_EVICT:  evict_v_o   = 1'b1;
                S_INSERT: begin
                    shift_r_o  = entries_p'(1);
                    ins_tag_o  = tag_reg;
                    ins_data_o = data_reg;
                    ins_stat_o = stat_reg;
                end
                default: ;
            endcase
        end
    end

    assign resp_hit_o   = resp_hit_reg;
    assign resp_data_o  = resp_data_reg;
    assign resp_stat_o  = resp_stat_reg;
    assign evict_tag_o  = evict_tag_reg;
    assign evict_data_o = evict_data_reg;
    assign evict_stat_o = evict_stat_reg;
    assign count_o      = count_reg;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            count_reg      <= '0;
            op_reg         <= 1'b0;
            tag_reg        <= '0;
            data_reg       <= '0;
            stat_reg       <= '0;
            resp_hit_reg   <= 1'b0;
            resp_data_reg  <= '0;
            resp_stat_reg  <= '0;
            evict_tag_reg  <= '0;
            evict_data_reg <= '0;
            evict_stat_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (req_v_i) begin
                        op_reg   <= req_op_i;
                        tag_reg  <= req_tag_i;
                        data_reg <= req_data_i;
                        // The valid bit is always set on what gets inserted.
                        stat_reg <= req_stat_i | stat_width'(1);
                    end
                end
                S_LOOKUP: begin
                    if (!op_reg) begin
                        resp_hit_reg  <= hit_any;
                        resp_data_reg <= hit_any ? cell_data[hit_idx] : '0;
                        resp_stat_reg <= hit_any ? cell_stat[hit_idx] : '0;
                    end
                    // Snapshot the oldest cell so evict_* stays stable even
                    // though the chain is not touched until after the handshake.
                    if (op_reg && !hit_any && (count_reg == full_count)) begin
                        evict_tag_reg  <= cell_tag[entries_p-1];
                        evict_data_reg <= cell_data[entries_p-1];
                        evict_stat_reg <= cell_stat[entries_p-1];
                    end
                    if (hit_any && (count_reg != '0)) begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                S_EVICT: begin
                    if (evict_ready_i && (count_reg != '0)) begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                S_INSERT: begin
                    if (count_reg != full_count) begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_vc_ctrl.sv
// Testbench for bp_vc_ctrl. A behavioural model of the external shift-cell
// chain reacts to the controller's pulses; expected pulses, responses and
// evictions are queued by the stimulus and checked by independent monitors.
module tb_bp_vc_ctrl;

    localparam int N  = 8;
    localparam int BW = 512;
    localparam int TW = 20;
    localparam int SW = 4;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          reset = 1'b1;
    logic          req_v_i = 1'b0;
    logic          req_ready_o;
    logic          req_op_i = 1'b0;
    logic [TW-1:0] req_tag_i = '0;
    logic [BW-1:0] req_data_i = '0;
    logic [SW-1:0] req_stat_i = '0;
    logic          resp_v_o;
    logic          resp_ready_i = 1'b1;
    logic          resp_hit_o;
    logic [BW-1:0] resp_data_o;
    logic [SW-1:0] resp_stat_o;
    logic          evict_v_o;
    logic          evict_ready_i = 1'b1;
    logic [TW-1:0] evict_tag_o;
    logic [BW-1:0] evict_data_o;
    logic [SW-1:0] evict_stat_o;
    logic [N*TW-1:0] cell_tag_i;
    logic [N*BW-1:0] cell_data_i;
    logic [N*SW-1:0] cell_stat_i;
    logic [N-1:0]  shift_r_o;
    logic [N-1:0]  shift_l_o;
    logic [TW-1:0] ins_tag_o;
    logic [BW-1:0] ins_data_o;
    logic [SW-1:0] ins_stat_o;
    logic [CW-1:0] count_o;

    bp_vc_ctrl #(
        .entries_p(N), .block_width(BW), .tag_width(TW), .stat_width(SW)
    ) dut (
        .clk_i(clk_i), .reset(reset),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_tag_i(req_tag_i), .req_data_i(req_data_i), .req_stat_i(req_stat_i),
        .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i), .resp_hit_o(resp_hit_o),
        .resp_data_o(resp_data_o), .resp_stat_o(resp_stat_o),
        .evict_v_o(evict_v_o), .evict_ready_i(evict_ready_i),
        .evict_tag_o(evict_tag_o), .evict_data_o(evict_data_o), .evict_stat_o(evict_stat_o),
        .cell_tag_i(cell_tag_i), .cell_data_i(cell_data_i), .cell_stat_i(cell_stat_i),
        .shift_r_o(shift_r_o), .shift_l_o(shift_l_o),
        .ins_tag_o(ins_tag_o), .ins_data_o(ins_data_o), .ins_stat_o(ins_stat_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- shift-cell chain model ----------------
    logic [TW-1:0] tag_m  [N];
    logic [BW-1:0] data_m [N];
    logic [SW-1:0] stat_m [N];
    logic [TW-1:0] tag_n  [N];
    logic [BW-1:0] data_n [N];
    logic [SW-1:0] stat_n [N];
    logic          r_on, l_on;

    always_comb begin
        tag_n  = tag_m;
        data_n = data_m;
        stat_n = stat_m;
        r_on   = 1'b0;
        l_on   = 1'b0;
        if (shift_r_o[0]) begin
            r_on      = 1'b1;
            tag_n[0]  = ins_tag_o;
            data_n[0] = ins_data_o;
            stat_n[0] = ins_stat_o;
        end
        for (int k = 1; k < N; k++) begin
            if (shift_r_o[k]) begin
                r_on      = 1'b1;
                tag_n[k]  = ins_tag_o;
                data_n[k] = ins_data_o;
                stat_n[k] = ins_stat_o;
            end else if (r_on) begin
                tag_n[k]  = tag_m[k-1];
                data_n[k] = data_m[k-1];
                stat_n[k] = stat_m[k-1];
            end
        end
        for (int k = 0; k < N - 1; k++) begin
            if (shift_l_o[k]) l_on = 1'b1;
            if (l_on) begin
                tag_n[k]  = tag_m[k+1];
                data_n[k] = data_m[k+1];
                stat_n[k] = stat_m[k+1];
            end
        end
        if (l_on || shift_l_o[N-1]) begin
            tag_n[N-1]  = '0;
            data_n[N-1] = '0;
            stat_n[N-1] = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < N; k++) begin
            if (reset) begin
                tag_m[k]  <= '0;
                data_m[k] <= '0;
                stat_m[k] <= '0;
            end else begin
                tag_m[k]  <= tag_n[k];
                data_m[k] <= data_n[k];
                stat_m[k] <= stat_n[k];
            end
        end
    end

    always_comb begin
        cell_tag_i  = '0;
        cell_data_i = '0;
        cell_stat_i = '0;
        for (int k = 0; k < N; k++) begin
            cell_tag_i[k*TW +: TW]  = tag_m[k];
            cell_data_i[k*BW +: BW] = data_m[k];
            cell_stat_i[k*SW +: SW] = stat_m[k];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic          is_r;
        logic [N-1:0]  vec;
        logic [TW-1:0] tag;
        logic [BW-1:0] data;
    } pulse_t;

    typedef struct {
        logic          hit;
        logic [BW-1:0] data;
        logic [SW-1:0] stat;
    } resp_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic [BW-1:0] data;
    } evict_t;

    pulse_t pq[$];
    resp_t  rq[$];
    evict_t eq[$];

    int tests = 0;
    int fails = 0;
    logic ev_seen = 1'b0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [BW-1:0] dat(input int t);
        return BW'(32'hA0 + t);
    endfunction

    function automatic pulse_t pr(input int t);
        pulse_t p;
        p.is_r = 1'b1; p.vec = N'(1); p.tag = TW'(t); p.data = dat(t);
        return p;
    endfunction

    function automatic pulse_t pl(input logic [N-1:0] v);
        pulse_t p;
        p.is_r = 1'b0; p.vec = v; p.tag = '0; p.data = '0;
        return p;
    endfunction

    // Pulse monitor.
    initial begin
        pulse_t p;
        forever begin
            @(negedge clk_i);
            if (shift_r_o != '0 || shift_l_o != '0) begin
                chk("pulse_exclusive", BW'(shift_r_o != '0 && shift_l_o != '0), '0);
                if (pq.size() == 0) begin
                    fail_now("unexpected_pulse");
                    $display("  shift_r=%0h shift_l=%0h", shift_r_o, shift_l_o);
                end else begin
                    p = pq.pop_front();
                    $display("[TB] pulse %s vec=%0h tag=%0h", p.is_r ? "R" : "L",
                             p.is_r ? shift_r_o : shift_l_o, ins_tag_o);
                    chk("pulse_dir", BW'(shift_r_o != '0), BW'(p.is_r));
                    chk("pulse_vec", BW'(p.is_r ? shift_r_o : shift_l_o), BW'(p.vec));
                    if (p.is_r) begin
                        chk("ins_tag", BW'(ins_tag_o), BW'(p.tag));
                        chk("ins_data", ins_data_o, p.data);
                        chk("ins_stat", BW'(ins_stat_o), BW'(4'h5));
                    end
                end
            end
        end
    end

    // Response monitor.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk_i);
            if (resp_v_o && resp_ready_i) begin
                if (rq.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    r = rq.pop_front();
                    $display("[TB] resp hit=%0b data=%0h stat=%0h", resp_hit_o, resp_data_o, resp_stat_o);
                    chk("resp_hit", BW'(resp_hit_o), BW'(r.hit));
                    chk("resp_data", resp_data_o, r.data);
                    chk("resp_stat", BW'(resp_stat_o), BW'(r.stat));
                end
            end
        end
    end

    // Evict monitor.
    initial begin
        evict_t e;
        forever begin
            @(negedge clk_i);
            if (evict_v_o) ev_seen = 1'b1;
            if (evict_v_o && evict_ready_i) begin
                if (eq.size() == 0) begin
                    fail_now("unexpected_evict");
                end else begin
                    e = eq.pop_front();
                    $display("[TB] evict tag=%0h data=%0h", evict_tag_o, evict_data_o);
                    chk("evict_tag", BW'(evict_tag_o), BW'(e.tag));
                    chk("evict_data", evict_data_o, e.data);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic op, input int t);
        int n;
        @(posedge clk_i); #1;
        req_v_i    = 1'b1;
        req_op_i   = op;
        req_tag_i  = TW'(t);
        req_data_i = dat(t);
        req_stat_i = 4'h4;
        n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) fail_now("req_accept_timeout");
        @(posedge clk_i); #1;
        req_v_i = 1'b0;
        $display("[TB] req op=%0d tag=%0h accepted", op, t);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) fail_now("idle_timeout");
    endtask

    task automatic wait_evict();
        int n;
        n = 0;
        @(negedge clk_i);
        while (!evict_v_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) fail_now("evict_timeout");
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        resp_t  r;
        evict_t e;

        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        resp_t  r;
        evict_t e;

        // Reset
        repeat (3) @(posedge clk_i);
        #1;
        reset = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", BW'(req_ready_o), BW'(1));
        chk("rst_count", BW'(count_o), BW'(0));
        chk("rst_shift_r", BW'(shift_r_o), BW'(0));
        chk("rst_shift_l", BW'(shift_l_o), BW'(0));
        chk("rst_resp_v", BW'(resp_v_o), BW'(0));
        chk("rst_evict_v", BW'(evict_v_o), BW'(0));

        // Three inserts
        for (int t = 1; t <= 3; t++) begin
            pq.push_back(pr(t));
            send(1'b1, t);
            wait_idle();
        end
        chk("count_after_3", BW'(count_o), BW'(3));
        chk("cell0", BW'(tag_m[0]), BW'(3));
        chk("cell1", BW'(tag_m[1]), BW'(2));
        chk("cell2", BW'(tag_m[2]), BW'(1));

        // Lookup hit on 0x2, with latency check
        pq.push_back(pl(8'h02));
        r.hit = 1'b1; r.data = dat(2); r.stat = 4'h5;
        rq.push_back(r);
        send(1'b0, 2);
        @(negedge clk_i);
        chk("lat_lookup_cycle", BW'(resp_v_o), BW'(0));
        @(negedge clk_i);
        chk("lat_resp_cycle", BW'(resp_v_o), BW'(1));
        wait_idle();
        chk("count_after_hit", BW'(count_o), BW'(2));

        // Lookup miss on 0xF
        r.hit = 1'b0; r.data = '0; r.stat = '0;
        rq.push_back(r);
        send(1'b0, 15);
        wait_idle();
        chk("count_after_miss", BW'(count_o), BW'(2));

        // Fill 1..8 from a clean state
        do_reset();
        for (int t = 1; t <= 8; t++) begin
            pq.push_back(pr(t));
            send(1'b1, t);
            wait_idle();
        end
        chk("count_full", BW'(count_o), BW'(8));

        // Insert 0x9 into full cache with delayed evict_ready
        e.tag = TW'(1); e.data = dat(1);
        eq.push_back(e);
        pq.push_back(pr(9));
        evict_ready_i = 1'b0;
        send(1'b1, 9);
        wait_evict();
        for (int i = 0; i < 3; i++) begin
            chk("evict_hold_v", BW'(evict_v_o), BW'(1));
            chk("evict_hold_tag", BW'(evict_tag_o), BW'(1));
            chk("evict_hold_data", evict_data_o, dat(1));
            chk("evict_no_shift", BW'(shift_r_o | shift_l_o), BW'(0));
            @(negedge clk_i);
        end
        @(posedge clk_i); #1;
        evict_ready_i = 1'b1;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        evict_ready_i = 1'b0;
        @(negedge clk_i);
        chk("bubble_shift_r", BW'(shift_r_o), BW'(0));
        chk("bubble_evict_v", BW'(evict_v_o), BW'(0));
        @(negedge clk_i);
        chk("insert_after_bubble", BW'(shift_r_o), BW'(8'h01));
        evict_ready_i = 1'b1;
        wait_idle();
        chk("count_after_evict", BW'(count_o), BW'(8));
        chk("newest_after_evict", BW'(tag_m[0]), BW'(9));

        // Duplicate insert 0x5: cells are [9,8,7,6,5,4,3,2], so 0x5 is at 4
        ev_seen = 1'b0;
        pq.push_back(pl(8'h10));
        pq.push_back(pr(5));
        send(1'b1, 5);
        wait_idle();
        chk("dup_no_evict", BW'(ev_seen), BW'(0));
        chk("count_after_dup", BW'(count_o), BW'(8));

        // Lookup 0x5: now at cell 0
        pq.push_back(pl(8'h01));
        r.hit = 1'b1; r.data = dat(5); r.stat = 4'h5;
        rq.push_back(r);
        send(1'b0, 5);
        wait_idle();
        chk("count_after_lookup5", BW'(count_o), BW'(7));

        // Refill, then reset during EVICT
        pq.push_back(pr(11));
        send(1'b1, 11);
        wait_idle();
        chk("count_refilled", BW'(count_o), BW'(8));
        evict_ready_i = 1'b0;
        send(1'b1, 10);
        wait_evict();
        @(posedge clk_i); #1;
        reset = 1'b1;
        @(negedge clk_i);
        chk("rst_mid_evict_v", BW'(evict_v_o), BW'(0));
        chk("rst_mid_shift", BW'(shift_r_o | shift_l_o), BW'(0));
        @(posedge clk_i); #1;
        reset = 1'b0;
        evict_ready_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst_ready", BW'(req_ready_o), BW'(1));
        chk("post_rst_count", BW'(count_o), BW'(0));
        chk("post_rst_evict_v", BW'(evict_v_o), BW'(0));
        repeat (3) @(negedge clk_i);

        chk("pulse_queue_empty", BW'(pq.size()), BW'(0));
        chk("resp_queue_empty", BW'(rq.size()), BW'(0));
        chk("evict_queue_empty", BW'(eq.size()), BW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bp_vc_ctrl.md
Name: bp_vc_ctrl

Overview:
Sequencing controller for the victim cache, which is a linear chain of shift cells. Each cell shifts in from its left or right neighbour on a one-hot start pulse that propagates through the chain. The controller accepts lookup and insert requests, does the tag compare across all cells, and drives the per-cell shift_r/shift_l start pulses. On insert into a full cache it hands the oldest entry out on an evict port. Valid entries always occupy cells 0..count-1 contiguously; cell 0 is the newest.

Parameters:
entries_p, 8, number of victim cache cells
block_width, 512, data block width in bits
tag_width, 20, tag width in bits
stat_width, 4, status width; stat bit 0 is the entry valid bit

Ports:
clk_i  in  1  clock
reset  in  1  synchronous, active-high reset
req_v_i  in  1  request valid
req_ready_o  out  1  request accepted when req_v_i & req_ready_o
req_op_i  in  1  0 = lookup-and-remove, 1 = insert
req_tag_i  in  tag_width  request tag
req_data_i  in  block_width  insert data
req_stat_i  in  stat_width  insert status; bit 0 is forced to 1 on insert
resp_v_o  out  1  lookup response valid
resp_ready_i  in  1  lookup response consumed
resp_hit_o  out  1  lookup hit
resp_data_o  out  block_width  data of the hit entry
resp_stat_o  out  stat_width  status of the hit entry
evict_v_o  out  1  evicted entry valid
evict_ready_i  in  1  evicted entry consumed
evict_tag_o / evict_data_o / evict_stat_o  out  tag/block/stat width  contents of cell entries_p-1
cell_tag_i  in  entries_p*tag_width  flattened cell tag outputs, cell 0 in the LSBs
cell_data_i  in  entries_p*block_width  flattened cell data outputs
cell_stat_i  in  entries_p*stat_width  flattened cell status outputs
shift_r_o  out  entries_p  one-hot shift-right start pulse
shift_l_o  out  entries_p  one-hot shift-left start pulse
ins_tag_o / ins_data_o / ins_stat_o  out  tag/block/stat width  left-neighbour input of cell 0
count_o  out  $clog2(entries_p+1)  number of valid entries

Behaviour:
- Reset: state IDLE, count_o=0, all valid outputs 0, shift_r_o=0, shift_l_o=0, ins_*=0, resp_*/evict_* data=0. Reset asserted in any state, including mid-EVICT or mid-RESP, returns to IDLE immediately and drops all pending responses.
- req_ready_o=1 only in IDLE and not in reset.
- A request is captured into internal registers (op, tag, data, stat) on acceptance.
- Integration requirement: the right-neighbour input of cell entries_p-1 is tied to zero, so a shift-left clears the last cell.
- Hit vector: hit[k] = cell_stat_i[k][0] & (cell_tag_i[k]==captured tag). Hit index = lowest set k.
- States: IDLE, LOOKUP, RESP, EVICT, SHIFT_OUT, INSERT.
- IDLE -> LOOKUP on request accept.
- LOOKUP, one cycle, compares the captured tag against all cells:
  - op=lookup, hit at k: latch cell k data/stat into resp regs, resp_hit=1; shift_l_o=1<<k for exactly this cycle; count-1; -> RESP.
  - op=lookup, miss: resp_hit=0, resp data=0, no shift -> RESP.
  - op=insert, hit at k: shift_l_o=1<<k this cycle; count-1; -> INSERT (duplicate is replaced, no eviction).
  - op=insert, miss, count<entries_p: -> INSERT.
  - op=insert, miss, count==entries_p: -> EVICT.
- RESP: resp_v_o=1, outputs held stable; on resp_ready_i -> IDLE. Lookup latency from accept to resp_v_o is 2 cycles.
- EVICT: evict_v_o=1; evict_* = contents of cell entries_p-1, registered at entry to EVICT and held stable; on evict_ready_i -> SHIFT_OUT, count-1.
- SHIFT_OUT: one bubble cycle so the cells are not touched during the evict handshake -> INSERT.
- INSERT: ins_* = captured request, with stat bit 0 set; shift_r_o=1 for exactly this cycle; count+1 -> IDLE.
- Boundaries: count never exceeds entries_p and never underflows. At most one of shift_r_o / shift_l_o is nonzero in any cycle, and it is one-hot. With entries_p=1, a full insert evicts cell 0 and then reinserts.

Test Plan:
- Reset held 3 cycles, then released -> req_ready_o=1, count_o=0, shift_r_o=shift_l_o=0, resp_v_o=evict_v_o=0.
- Insert tags 0x1, 0x2, 0x3 (data 0xA1, 0xA2, 0xA3) -> each gives a single-cycle shift_r_o=8'h01 with ins_tag_o equal to the tag; final count_o=3; cells hold [0x3, 0x2, 0x1].
- Lookup 0x2 -> 2 cycles after accept resp_v_o=1, resp_hit_o=1, resp_data_o=0xA2; shift_l_o=8'h02 for one cycle; count_o=2. Lookup 0xF -> resp_hit_o=0, no shift, count unchanged.
- Fill 8 entries (tags 0x1..0x8), insert 0x9 with evict_ready_i low for 3 cycles -> evict_v_o held with evict_tag_o=0x1 and stable data; after ready: one bubble cycle, then shift_r_o=8'h01; count_o stays 8.
- Insert duplicate 0x5 into a full cache -> shift_l_o at the index of 0x5, then shift_r_o=8'h01; evict_v_o never asserted; count_o=8.
- Assert reset during EVICT -> next cycle evict_v_o=0, state IDLE, count_o=0, no shift pulses.
